serial_adder: RTL and testbench

Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus a carry-in, processing DIGIT bits per clock through an internal DIGIT-bit ripple chain of full-adder cells. Operands enter through a start/busy/done handshake and results stay registered until the next operation. It is the sequential, width-generic successor to the single-bit full adder and is used where area matters more than latency.

---
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit x + y + cin, DIGIT bits per clock through a ripple chain.
// Optional feature macro: SERIAL_ADDER_SUB_EN (sub input selects x - y).
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] xr;
   logic [WIDTH-1:0] yr;
   logic [WIDTH-1:0] y_eff;
   logic [WIDTH-1:0] s_next;
   logic [DIGIT-1:0] sum_d;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cy;
   logic             xmsb;
   logic             ymsb;
   logic             eff_sub;

`ifdef SERIAL_ADDER_SUB_EN
   assign eff_sub = sub;
`else
   // Port kept for drop-in compatibility; forced to addition.
   assign eff_sub = sub & 1'b0;
`endif

   assign y_eff = eff_sub ? ~y : y;

   always_comb begin
      sum_d = '0;
      cy    = carry;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         sum_d[i] = xr[i] ^ yr[i] ^ cy;
         cy       = (xr[i] & yr[i]) | (cy & (xr[i] ^ yr[i]));
      end
   end

   // New digit enters at the top; after N steps the LSB digit reaches bit 0.
   assign s_next = (s >> DIGIT) | (WIDTH'(sum_d) << (WIDTH - DIGIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         xr    <= '0;
         yr    <= '0;
         carry <= 1'b0;
         xmsb  <= 1'b0;
         ymsb  <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  xr    <= x;
                  yr    <= y_eff;
                  carry <= eff_sub ? 1'b1 : cin;
                  xmsb  <= x[WIDTH-1];
                  ymsb  <= y_eff[WIDTH-1];
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               xr    <= xr >> DIGIT;
               yr    <= yr >> DIGIT;
               s     <= s_next;
               carry <= cy;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  cout  <= cy;
                  ovf   <= (xmsb == ymsb) && (s_next[WIDTH-1] != xmsb);
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: four instances (8/1, 8/4, 3/1, 3/3) against an arithmetic model.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] x8 = '0, y8 = '0;
   logic [2:0] x3 = '0, y3 = '0;
   logic       cin = 1'b0, sub = 1'b0;
   logic [3:0] st = '0;

   logic       bo[4], dn[4], co[4], ov[4];
   logic [7:0] s0, s1;
   logic [2:0] s2, s3;
   logic [7:0] so[4];

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   always_comb begin
      so[0] = s0;
      so[1] = s1;
      so[2] = {5'b0, s2};
      so[3] = {5'b0, s3};
   end

   serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .start(st[0]), .x(x8), .y(y8),
      .cin(cin), .sub(sub), .busy(bo[0]), .done(dn[0]), .s(s0), .cout(co[0]), .ovf(ov[0]));
   serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst(rst), .start(st[1]), .x(x8), .y(y8),
      .cin(cin), .sub(sub), .busy(bo[1]), .done(dn[1]), .s(s1), .cout(co[1]), .ovf(ov[1]));
   serial_adder #(.WIDTH(3), .DIGIT(1)) u2 (.clk(clk), .rst(rst), .start(st[2]), .x(x3), .y(y3),
      .cin(cin), .sub(sub), .busy(bo[2]), .done(dn[2]), .s(s2), .cout(co[2]), .ovf(ov[2]));
   serial_adder #(.WIDTH(3), .DIGIT(3)) u3 (.clk(clk), .rst(rst), .start(st[3]), .x(x3), .y(y3),
      .cin(cin), .sub(sub), .busy(bo[3]), .done(dn[3]), .s(s3), .cout(co[3]), .ovf(ov[3]));

   function automatic int nk(input int k);
      case (k)
         0: return 8;
         1: return 2;
         2: return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int wk(input int k);
      return (k < 2) ? 8 : 3;
   endfunction

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic void model(input int w, input int xa, input int ya, input bit ci, input bit sb,
                                 output logic [7:0] es, output logic ec, output logic eo);
      int m, xs, ys, r, sr;
      bit sube;
`ifdef SERIAL_ADDER_SUB_EN
      sube = sb;
`else
      sube = 1'b0;
`endif
      m  = 1 << w;
      xs = (xa >= m / 2) ? xa - m : xa;
      ys = (ya >= m / 2) ? ya - m : ya;
      if (sube) begin
         r  = xa - ya;
         sr = xs - ys;
         ec = (xa >= ya);
      end else begin
         r  = xa + ya + int'(ci);
         sr = xs + ys + int'(ci);
         ec = (r >= m);
      end
      es = 8'((r + m) % m);
      eo = (sr < -(m / 2)) || (sr > m / 2 - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input int k, input logic [7:0] xa, input logic [7:0] ya, input logic ci,
                         input logic sb, input logic [7:0] es, input logic ec, input logic eo,
                         input int poke, input string nm);
      int n;
      n = nk(k);
      @(negedge clk);
      if (k < 2) begin x8 = xa; y8 = ya; end
      else begin x3 = xa[2:0]; y3 = ya[2:0]; end
      cin = ci;
      sub = sb;
      st[k] = 1'b1;
      @(posedge clk); #1;
      st[k] = 1'b0;
      x8  = 8'($urandom);
      y8  = 8'($urandom);
      x3  = 3'($urandom);
      y3  = 3'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      chk($sformatf("%s_busy_t0", nm), bo[k], 1);
      chk($sformatf("%s_done_t0", nm), dn[k], 0);
      for (int i = 1; i <= n; i++) begin
         if (i == poke) begin
            st[k] = 1'b1;
            x8 = ~xa;
            y8 = ~ya;
         end
         @(posedge clk); #1;
         st[k] = 1'b0;
         if (i < n) begin
            chk($sformatf("%s_busy_run%0d", nm, i), bo[k], 1);
            chk($sformatf("%s_done_run%0d", nm, i), dn[k], 0);
         end else begin
            chk($sformatf("%s_busy_done", nm), bo[k], 0);
            chk($sformatf("%s_done_pulse", nm), dn[k], 1);
            chk($sformatf("%s_s", nm), so[k], es);
            chk($sformatf("%s_cout", nm), co[k], ec);
            chk($sformatf("%s_ovf", nm), ov[k], eo);
         end
      end
      @(posedge clk); #1;
      chk($sformatf("%s_done_end", nm), dn[k], 0);
      chk($sformatf("%s_busy_end", nm), bo[k], 0);
      chk($sformatf("%s_s_hold", nm), so[k], es);
   endtask

   initial begin
      logic [7:0] es;
      logic ec, eo;
      logic [7:0] ra, rb;
      logic rc, rs;

      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst%0d_busy", k), bo[k], 0);
         chk($sformatf("rst%0d_done", k), dn[k], 0);
         chk($sformatf("rst%0d_s", k), so[k], 0);
         chk($sformatf("rst%0d_cout", k), co[k], 0);
         chk($sformatf("rst%0d_ovf", k), ov[k], 0);
      end
      @(negedge clk);
      rst = 1'b0;

      run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, "add7f01");
      run_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, "d4_a55a");
`ifdef SERIAL_ADDER_SUB_EN
      run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0, "sub0507");
      run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0, "sub8001");
`else
      run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 0, "sub0507");
      run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 0, "sub8001");
`endif

      // start re-pulsed mid-RUN with inverted operands must be ignored
      model(8, 8'h3C, 8'h29, 1'b1, 1'b0, es, ec, eo);
      run_op(0, 8'h3C, 8'h29, 1'b1, 1'b0, es, ec, eo, 3, "poke");
      model(8, 8'hC8, 8'h11, 1'b0, 1'b0, es, ec, eo);
      run_op(1, 8'hC8, 8'h11, 1'b0, 1'b0, es, ec, eo, 2, "poke4");

      // asynchronous abort after the third RUN edge
      @(negedge clk);
      x8 = 8'h12; y8 = 8'h34; cin = 1'b0; sub = 1'b0; st[0] = 1'b1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_busy", bo[0], 0);
      chk("abort_done", dn[0], 0);
      chk("abort_s", so[0], 0);
      chk("abort_cout", co[0], 0);
      chk("abort_ovf", ov[0], 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk($sformatf("abort_nodone%0d", i), dn[0], 0);
      end
      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, "postrst");

      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < 2; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(8, int'(ra), int'(rb), rc, rs, es, ec, eo);
            run_op(k, ra, rb, rc, rs, es, ec, eo, 0, $sformatf("rnd%0d_%0d", k, i));
         end
      end

      for (int k = 2; k < 4; k++) begin
         for (int v = 0; v < 128; v++) begin
            ra = 8'(v & 7);
            rb = 8'((v >> 3) & 7);
            rc = 1'(v >> 6);
            model(3, int'(ra), int'(rb), rc, 1'b0, es, ec, eo);
            run_op(k, ra, rb, rc, 1'b0, es, ec, eo, 0, $sformatf("ex%0d_%0d", k, v));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
